// File: rtl/cond_status_unit_pkg.sv
// Shared definitions for the conditional-execution status unit:
// condition encodings, flag bit positions and a small popcount helper.
package cond_status_unit_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Flag register layout is {Z,C,N,V} in bits 3..0.
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // Number of set bits in a (zero-extended) lane mask of up to four lanes.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/cond_status_unit_cond_eval.sv
// Purely combinational condition check: one 4-bit condition field against
// one set of {Z,C,N,V} flags.
module condition_eval
  import cond_status_unit_pkg::*;
(
  input  logic [3:0] i_Cond,
  input  logic [3:0] i_Flags,
  output logic       o_Pass
);

  logic w_z;
  logic w_c;
  logic w_n;
  logic w_v;

  assign w_z = i_Flags[FLAG_Z];
  assign w_c = i_Flags[FLAG_C];
  assign w_n = i_Flags[FLAG_N];
  assign w_v = i_Flags[FLAG_V];

  // Decode the condition field into a pass/fail bit.
  always_comb begin
    o_Pass = 1'b0;
    case (cond_e'(i_Cond))
      COND_EQ: o_Pass = w_z;
      COND_NE: o_Pass = ~w_z;
      COND_CS: o_Pass = w_c;
      COND_CC: o_Pass = ~w_c;
      COND_MI: o_Pass = w_n;
      COND_PL: o_Pass = ~w_n;
      COND_VS: o_Pass = w_v;
      COND_VC: o_Pass = ~w_v;
      COND_HI: o_Pass = w_c & ~w_z;
      COND_LS: o_Pass = ~w_c | w_z;
      COND_GE: o_Pass = (w_n == w_v);
      COND_LT: o_Pass = (w_n != w_v);
      COND_GT: o_Pass = ~w_z & (w_n == w_v);
      COND_LE: o_Pass = w_z | (w_n != w_v);
      COND_AL: o_Pass = 1'b1;
      COND_NV: o_Pass = 1'b0;
      default: o_Pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_status_unit.sv
// Multi-lane condition evaluation with a shared {Z,C,N,V} status register.
// Lanes are in program order (lane 0 oldest); optionally a younger lane sees
// flags written by older committing lanes in the same cycle.
module cond_status_unit
  import cond_status_unit_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int FLAG_FWD = 1,
  parameter int CNT_W    = 16
)
(
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic [LANES-1:0]   i_Valid,
  input  logic [4*LANES-1:0] i_Condition,
  input  logic [LANES-1:0]   i_Set_Flags,
  input  logic [4*LANES-1:0] i_Flags_New,
  input  logic               i_Status_Wr,
  input  logic [3:0]         i_Status_Wdata,
  input  logic               i_Stall,
  input  logic               i_Flush,
  output logic [LANES-1:0]   o_Valid,
  output logic [LANES-1:0]   o_Result,
  output logic [3:0]         o_Status,
  output logic [CNT_W-1:0]   o_Exec_Count,
  output logic [CNT_W-1:0]   o_Skip_Count
);

  logic [LANES-1:0] r_valid;
  logic [LANES-1:0] r_result;
  logic [3:0]       r_status;
  logic [CNT_W-1:0] r_exec_cnt;
  logic [CNT_W-1:0] r_skip_cnt;

  logic             w_active;
  logic [LANES-1:0] w_pass;
  logic [LANES-1:0] w_upd;
  logic [LANES-1:0] w_exec_lanes;
  logic [LANES-1:0] w_skip_lanes;
  logic [2:0]       w_exec_pop;
  logic [2:0]       w_skip_pop;
  logic [3:0]       w_status_next;

  // Flush kills the cycle outright; stall freezes it. Either way nothing commits.
  assign w_active = ~i_Stall & ~i_Flush;

  // Per-lane evaluation. The chain carries "flags after lanes 0..k" so that
  // its last stage is also the next status value from lane writes.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [3:0] w_chain_in;
    logic [3:0] w_chain_out;
    logic [3:0] w_eff;
    logic       w_pass_k;
    logic       w_upd_k;

    if (k == 0) begin : g_first
      assign w_chain_in = r_status;
    end else begin : g_rest
      assign w_chain_in = g_lane[k-1].w_chain_out;
    end

    assign w_eff = (FLAG_FWD != 0) ? w_chain_in : r_status;

    condition_eval u_condition_eval (
      .i_Cond  (i_Condition[4*k +: 4]),
      .i_Flags (w_eff),
      .o_Pass  (w_pass_k)
    );

    // A lane only writes flags when it actually executes.
    assign w_upd_k     = i_Valid[k] & w_pass_k & w_active & i_Set_Flags[k];
    assign w_chain_out = w_upd_k ? i_Flags_New[4*k +: 4] : w_chain_in;
    assign w_pass[k]   = w_pass_k;
    assign w_upd[k]    = w_upd_k;
  end

  assign w_exec_lanes = i_Valid & w_pass;
  assign w_skip_lanes = i_Valid & ~w_pass;
  assign w_exec_pop   = popcount4(4'(w_exec_lanes));
  assign w_skip_pop   = popcount4(4'(w_skip_lanes));

  // Next flags: youngest flag-writing lane wins, MSR write only if no lane wrote.
  always_comb begin
    w_status_next = r_status;
    if (w_upd != '0) begin
      w_status_next = g_lane[LANES-1].w_chain_out;
    end else if (i_Status_Wr && w_active) begin
      w_status_next = i_Status_Wdata;
    end else begin
      w_status_next = r_status;
    end
  end

  // Pipeline registers, status register and statistics counters.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_valid    <= '0;
      r_result   <= '0;
      r_status   <= 4'b0000;
      r_exec_cnt <= '0;
      r_skip_cnt <= '0;
    end else if (i_Flush) begin
      r_valid  <= '0;
      r_result <= '0;
    end else if (!i_Stall) begin
      r_valid    <= i_Valid;
      r_result   <= w_exec_lanes;
      r_status   <= w_status_next;
      r_exec_cnt <= r_exec_cnt + CNT_W'(w_exec_pop);
      r_skip_cnt <= r_skip_cnt + CNT_W'(w_skip_pop);
    end
  end

  assign o_Valid      = r_valid;
  assign o_Result     = r_result;
  assign o_Status     = r_status;
  assign o_Exec_Count = r_exec_cnt;
  assign o_Skip_Count = r_skip_cnt;

endmodule

// File: doc/cond_status_unit.md
COND_STATUS_UNIT -- requirements
Module: cond_status_unit

Interface
REQ-001 SHALL have parameter LANES, default 2 (range 1..4): instructions evaluated per cycle, in program order lane 0 first.
REQ-002 SHALL have parameter FLAG_FWD, default 1: 1 = lane k sees flags committed by lanes 0..k-1 in the same cycle; 0 = all lanes see the registered flags.
REQ-003 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-004 i_Clk  input  1  single clock, rising edge.
REQ-005 i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_Valid  input  LANES  per-lane instruction valid.
REQ-007 i_Condition  input  4*LANES  per-lane condition field; lane k uses bits [4k+3:4k].
REQ-008 i_Set_Flags  input  LANES  per-lane S-bit: the instruction writes the flags.
REQ-009 i_Flags_New  input  4*LANES  per-lane ALU flag result, {Z,C,N,V} in bits 3..0.
REQ-010 i_Status_Wr  input  1  direct flag write (MSR).
REQ-011 i_Status_Wdata  input  4  MSR data, {Z,C,N,V}.
REQ-012 i_Stall  input  1  hold all state; inputs ignored.
REQ-013 i_Flush  input  1  kill all lanes this cycle.
REQ-014 o_Valid  output  LANES  registered per-lane valid.
REQ-015 o_Result  output  LANES  registered per-lane condition pass.
REQ-016 o_Status  output  4  current flag register, {Z,C,N,V}.
REQ-017 o_Exec_Count, o_Skip_Count  output  CNT_W each  counts of passed and failed valid lanes.

Function
REQ-018 Condition table: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
REQ-019 Lane k commits when i_Valid[k] and pass[k] and no flush and no stall.
REQ-020 Effective flags for lane k: with FLAG_FWD=1, i_Flags_New of the highest-numbered lane j<k with a commit and i_Set_Flags[j], else r_Status; with FLAG_FWD=0, r_Status.
REQ-021 Next r_Status: i_Flags_New of the highest committing lane with i_Set_Flags set; if there is none, i_Status_Wdata when i_Status_Wr; otherwise unchanged.
REQ-022 A lane that fails its condition SHALL NOT update the flags, even when i_Set_Flags is set.
REQ-023 Latency is 1 cycle: o_Valid[k] <= i_Valid[k] and o_Result[k] <= pass[k] & i_Valid[k]; o_Result = 0 wherever o_Valid = 0.
REQ-024 i_Flush: o_Valid <= 0, o_Result <= 0; the flags, counters and MSR write are all suppressed. Flush has priority over stall.
REQ-025 i_Stall without flush: outputs, r_Status and the counters hold; i_Status_Wr is ignored.
REQ-026 Counters: add the popcount of valid passed lanes and the popcount of valid failed lanes each non-stalled, non-flushed cycle; wrap modulo 2^CNT_W.
REQ-027 o_Status = r_Status, registered, with no combinational path from the inputs.

Reset
REQ-028 While i_Rst_n = 0: o_Valid = 0, o_Result = 0, r_Status = 4'b0000, both counters = 0; the assertion takes effect immediately, independent of i_Clk.
REQ-029 Reset asserted mid-operation discards in-flight results; the first valid output appears 1 cycle after the first valid input following deassertion.

Structure
REQ-030 The shared package SHALL hold: the condition encodings (COND_EQ..COND_NV); flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0.
REQ-031 The combinational sub-module condition_eval (4-bit condition, 4-bit flags -> pass) SHALL be instantiated once per lane; the flag-forward chain and all registers live in the top level.

Verification
REQ-032 LANES=1, r_Status=0000; each of the 16 conditions, with and without the relevant flag set -> o_Result matches REQ-018 one cycle later; NV always gives 0 and AL always gives 1.
REQ-033 LANES=2, FLAG_FWD=1, r_Status=0000: lane0 AL with Set_Flags and Flags_New=1000, lane1 EQ -> o_Result=11, o_Status=1000.
REQ-034 Same stimulus as REQ-033 with FLAG_FWD=0 -> o_Result=01 (lane1 fails), o_Status=1000.
REQ-035 Lane0 NE fails with Set_Flags and Flags_New=0100, while i_Status_Wr with Wdata=0011 in the same cycle -> o_Status=0011; Skip_Count increments by 1.
REQ-036 i_Stall and i_Flush asserted together with two valid AL lanes -> o_Valid=00, o_Status and counters unchanged; then stall alone -> outputs hold for 3 cycles.
REQ-037 CNT_W=4, Exec_Count=15, two valid AL lanes -> Exec_Count=1; asynchronous reset mid-cycle -> all outputs 0 before the next clock edge.
